reg_bus_master: RTL
===================

# reg_bus_master

Initiator side of the on-chip byte register bus: converts a host byte command stream (from the host link) into single-cycle register read and write strobes. Register slaves latch write data on `cs && we` and drive the shared read bus combinationally when `cs && !we`. This block owns that bus. It returns read data as a response byte.

## Interface

Parameters:
- `NUM_REGS`, default 8: number of register slaves, 1..128; each has one `reg_cs` bit.

Ports:
- `clk`  in  1  system clock; every flop is clocked on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_data`  in  8  host command stream byte.
- `cmd_valid`  in  1  `cmd_data` is valid.
- `cmd_ready`  out  1  block accepts `cmd_data` this cycle.
- `rsp_data`  out  8  read response byte.
- `rsp_valid`  out  1  `rsp_data` is valid.
- `rsp_ready`  in  1  host consumes the response.
- `reg_cs`  out  NUM_REGS  one-hot register select.
- `reg_we`  out  1  write strobe; qualifies `reg_cs`.
- `reg_wdata`  out  8  write data driven to every slave.
- `reg_rdata`  in  8  shared read bus, driven by the selected slave while `cs && !we`.
- `bad_addr`  out  1  one-cycle pulse when a command addresses `>= NUM_REGS`.

## Operation

- Command byte format:
  - bit 7 = 1 means write, 0 means read.
  - bits 6:0 = register address.
- A write command is followed by exactly one data byte on the same stream.
- A byte is accepted on a cycle with `cmd_valid && cmd_ready`.
- FSM states: IDLE, WDATA, WSTROBE, RSTROBE, RESP.
  - IDLE: `cmd_ready`=1. On accept, latch address and direction; write goes to WDATA, read goes to RSTROBE.
  - WDATA: `cmd_ready`=1. On accept, latch the byte into `reg_wdata`, then go to WSTROBE.
  - WSTROBE: `reg_cs[addr]`=1 and `reg_we`=1 for exactly one cycle, then go to IDLE.
  - RSTROBE: `reg_cs[addr]`=1 and `reg_we`=0 for exactly one cycle. `reg_rdata` is captured into `rsp_data` at the end of this cycle, then go to RESP.
  - RESP: `rsp_valid`=1 and `rsp_data` stays stable until `rsp_ready`, then go to IDLE. `cmd_ready`=0.
- Out-of-range address (`>= NUM_REGS`):
  - The full command is still consumed, including the data byte of a write.
  - No `reg_cs` bit is asserted.
  - A read returns 0x00.
  - `bad_addr` pulses in the strobe cycle.
- Bus protocol rules:
  - `reg_cs` is all-zero outside the strobe states.
  - At most one `reg_cs` bit is ever set.
  - `reg_we` is never high without a `reg_cs` bit, except as noted: `reg_we` may be 0 whenever `reg_cs` is 0.
- `cmd_ready` is 0 in WSTROBE, RSTROBE and RESP, so commands do not overlap.
- Reset values: `cmd_ready`=0 during the reset cycle and 1 afterwards (IDLE). `rsp_valid`, `rsp_data`, `reg_cs`, `reg_we`, `reg_wdata` and `bad_addr` all reset to 0.
- Reset mid-operation:
  - Any pending write is dropped; no strobe is issued after `rst`.
  - A pending response is discarded; `rsp_valid` drops on the next edge.

## Timing

- All outputs come from registers. No combinational path from `cmd_*` or `rsp_ready` to any output.
- Write: data byte accepted at edge N; `reg_cs` and `reg_we` are high in cycle N..N+1; the slave latches at edge N+1. `cmd_ready` returns at N+1.
- Write throughput: one write per 3 cycles with `cmd_valid` held high.
- Read: command accepted at edge N; `reg_cs` is high in cycle N..N+1; `reg_rdata` is sampled at edge N+1; `rsp_valid` is high from N+1.
- With `rsp_ready` held high, `rsp_valid` lasts one cycle and IDLE resumes at N+2.
- `rsp_ready` arriving while `rsp_valid` is 0 is ignored.
- `cmd_valid` deasserted in WDATA stalls the block indefinitely; no timeout.

## Structure

- Shared package `reg_bus_pkg`:
  - FSM state enum.
  - `CMD_WRITE_BIT = 7`.
  - `CMD_ADDR_W = 7`.
  - `REG_DATA_W = 8`.
- One natural sub-module, `reg_addr_decode`: address plus enable in, one-hot `NUM_REGS` select and range-error flag out. The decoder's select output is registered in the master.

## Test plan

- Write 0x85 then 0xA5, `NUM_REGS`=8: `reg_cs`=0x20 and `reg_we`=1 for exactly one cycle with `reg_wdata`=0xA5; a model register 5 then holds 0xA5.
- Read 0x05 with the model driving 0xA5, `rsp_ready`=1: `reg_cs`=0x20 and `reg_we`=0 for one cycle; `rsp_data`=0xA5 and `rsp_valid`=1 two cycles after accept, for one cycle.
- Read with `rsp_ready` held 0 for 10 cycles: `rsp_valid`/`rsp_data` stable, `cmd_ready`=0 throughout; the next command is accepted the cycle after `rsp_ready`.
- Write 0x8A,0x11 then read 0x0A (out of range): no `reg_cs` bit ever set, `bad_addr` pulses twice, read returns 0x00.
- Back-to-back 0x83,0x3C,0x03 with `cmd_valid` always high: strobes at expected cycles, response 0x3C, no overlapping `reg_cs`.
- `rst` asserted in WDATA and again in RESP: no strobe follows, `rsp_valid`=0 next cycle, `cmd_ready`=1 one cycle after `rst` drops.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared types and field positions for the byte register bus
package reg_bus_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WSTROBE,
    RSTROBE,
    RESP
  } state_e;
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam int REG_DATA_W = 8;
endpackage

// File: rtl/reg_bus_master_if.sv
// reg_bus_master_if: host command/response streams plus the shared register bus
interface reg_bus_master_if #(parameter int NUM_REGS = 8);
  import reg_bus_pkg::*;
  logic [REG_DATA_W-1:0] cmd_data;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [REG_DATA_W-1:0] rsp_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [NUM_REGS-1:0]   reg_cs;
  logic                  reg_we;
  logic [REG_DATA_W-1:0] reg_wdata;
  logic [REG_DATA_W-1:0] reg_rdata;
  logic                  bad_addr;
  modport master (
    input  cmd_data, cmd_valid, rsp_ready, reg_rdata,
    output cmd_ready, rsp_data, rsp_valid, reg_cs, reg_we, reg_wdata, bad_addr
  );
  modport slave (
    output cmd_data, cmd_valid, rsp_ready, reg_rdata,
    input  cmd_ready, rsp_data, rsp_valid, reg_cs, reg_we, reg_wdata, bad_addr
  );
endinterface

// File: rtl/reg_addr_decode.sv
// reg_addr_decode: one-hot register select and out-of-range flag for an enabled address
module reg_addr_decode
  import reg_bus_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic [CMD_ADDR_W-1:0] addr,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   sel,
  output logic                  err
);
  logic hit;
  assign hit = int'(addr) < NUM_REGS;
  assign sel = (en && hit) ? NUM_REGS'(1) << addr : '0;
  assign err = en && !hit;
endmodule

// File: rtl/reg_bus_master.sv
// reg_bus_master: turns a host byte command stream into single-cycle register strobes
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  reg_bus_master_if.master bus
);
  state_e                state_q, state_d;
  logic [CMD_ADDR_W-1:0] addr_q, addr_d, dec_addr;
  logic [REG_DATA_W-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [NUM_REGS-1:0]   cs_q, cs_d, sel;
  logic                  we_q, we_d, bad_q, bad_d;
  logic                  cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic                  accept, launch, err;
  assign accept = bus.cmd_valid && cmd_ready_q;
  // a strobe is launched by a read command or by the data byte of a write
  assign launch = accept && (state_q == WDATA || !bus.cmd_data[CMD_WRITE_BIT]);
  // reads decode the incoming command directly, writes the address latched earlier
  assign dec_addr = state_q == IDLE ? bus.cmd_data[CMD_ADDR_W-1:0] : addr_q;
  reg_addr_decode #(.NUM_REGS(NUM_REGS)) u_dec (
    .addr(dec_addr),
    .en  (launch),
    .sel (sel),
    .err (err)
  );
  // next state of the command FSM
  always_comb begin
    case (state_q)
      IDLE:    state_d = accept ? (bus.cmd_data[CMD_WRITE_BIT] ? WDATA : RSTROBE) : IDLE;
      WDATA:   state_d = accept ? WSTROBE : WDATA;
      WSTROBE: state_d = IDLE;
      RSTROBE: state_d = RESP;
      RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // next values of the registered outputs; strobes and bad_addr last one cycle
  always_comb begin
    addr_d      = (state_q == IDLE && accept) ? bus.cmd_data[CMD_ADDR_W-1:0] : addr_q;
    wdata_d     = (state_q == WDATA && accept) ? bus.cmd_data : wdata_q;
    cs_d        = sel;
    we_d        = launch && state_q == WDATA && !err;
    bad_d       = err;
    cmd_ready_d = (state_q == IDLE || state_q == WDATA) ? !launch :
                  state_q == WSTROBE || (state_q == RESP && bus.rsp_ready);
    rsp_valid_d = state_q == RSTROBE || (state_q == RESP && !bus.rsp_ready);
    rsp_data_d  = state_q == RSTROBE ? (|cs_q ? bus.reg_rdata : '0) : rsp_data_q;
  end
  // state and output registers; reset drops any pending write or response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      cs_q        <= '0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      bad_q       <= bad_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.reg_cs    = cs_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.bad_addr  = bad_q;
endmodule
